rnn_step_ctrl: RTL and testbench
================================

Name: rnn_step_ctrl

Overview:
- Sequences one recurrent time step h_t = act(W·x + U·h_{t-1}) over the existing rnn register-array storage: input vector, W matrix (rnn_0) and recurrent U matrix (rnn_1).
- Time-shares a single signed multiply-accumulate unit across all products.
- Owns the hidden-state register file; the host bus wrapper starts it and reads results back.
- Sits beside the address-decoded host slave inside rnn.

Parameters:
- IN_DIM, 2, input vector length (rows of W)
- HID_DIM, 4, hidden units (cols of W; rows/cols of U)
- DW, 16, signed fixed-point data width
- FRAC, 8, fractional bits (Q8.8)
- ACC_W, 40, accumulator width
- ACT_RELU, 1, 1 = ReLU activation, 0 = identity

Ports:
- clk, in, 1, system clock
- rst_n, in, 1, asynchronous active-low reset
- start, in, 1, request one time step; sampled in IDLE only
- clear_h, in, 1, zero hidden state; honoured in IDLE only
- busy, out, 1, step in progress
- done, out, 1, one-cycle pulse at step completion
- x_idx, out, $clog2(IN_DIM), input vector read index
- x_data, in, DW, input vector element (combinational read)
- w_row, out, 8, W row address
- w_col, out, 8, W column address
- w_data, in, DW, W element (combinational read)
- u_row, out, 8, U row address
- u_col, out, 8, U column address
- u_data, in, DW, U element (combinational read)
- h_rd_idx, in, $clog2(HID_DIM), host readback index
- h_rd_data, out, DW, h[h_rd_idx] (combinational)

Behaviour:
- Reset (asynchronous, any state): FSM to IDLE; busy=0; done=0; all h and h_next =0; accumulator =0; all index outputs =0.
- States: IDLE, ACC_X, ACC_H, WRITE, COMMIT, DONE.
- IDLE:
  - clear_h=1 zeroes h next edge and takes priority; start in the same cycle is ignored.
  - Otherwise start=1 moves to ACC_X with j=0, i=0, acc=0.
- ACC_X, IN_DIM cycles: x_idx=i, w_row=i, w_col=j; acc += x_data*w_data (full 2·DW product, sign-extended to ACC_W). After i=IN_DIM-1, go to ACC_H with k=0.
- ACC_H, HID_DIM cycles: u_row=k, u_col=j; acc += h[k]*u_data. h is the previous-step value; h_next is not read. After k=HID_DIM-1, go to WRITE.
- WRITE, 1 cycle:
  - r = acc >>> FRAC (arithmetic shift, truncation toward -inf).
  - Saturate r to [-2^(DW-1), 2^(DW-1)-1].
  - If ACT_RELU, negative values become 0.
  - h_next[j] = result; acc cleared.
  - If j<HID_DIM-1: j++, back to ACC_X. Else go to COMMIT.
- COMMIT, 1 cycle: h <= h_next for all units simultaneously.
- DONE, 1 cycle: done=1; busy=0. Then IDLE.
- busy: 1 in ACC_X, ACC_H, WRITE, COMMIT; 0 in IDLE and DONE.
- Latency: start sampled at edge 0; done high for HID_DIM*(IN_DIM+HID_DIM+1)+1 cycles later. Defaults: done high in cycle 30.
- start while busy or in DONE is ignored; no queueing.
- clear_h while not in IDLE is ignored.
- Read addresses are registered and change only on clock edges. Matrix/vector writes by the host during busy give undefined results; the host must not do this.
- h_rd_data is valid at all times. It shows committed h, never partial h_next.
- Accumulator never wraps for default dims: the worst-case sum of 6 full-scale products fits in 40 bits.

Decomposition:
- Package rnn_pkg holds:
  - DW, FRAC, IN_DIM, HID_DIM, ACC_W
  - typedef fixed_t (signed DW)
  - typedef acc_t (signed ACC_W)
  - enum ctrl_state_t
- Sub-module rnn_mac:
  - Inputs: clear, en, a, b. Output: registered acc.
  - Provides shift/saturate/ReLU as a combinational output.
  - The FSM sequences rnn_mac and owns the h/h_next arrays.

Test Plan:
- Q8.8 basic step: h=0, x=[256,0], W row0=[256,512,-256,128], W row1=0, U=0, start -> done at cycle 30; h=[256,512,0,128] (ReLU clips -256).
- Recurrence: after the basic step, set x=[0,0] and U=256·identity, start -> h unchanged [256,512,0,128]. Then set U[0][1]=256 and run again -> h[1]=768.
- Saturation and ACT_RELU=0: x=[32767,32767], all W=32767 -> h all 32767. W all -32768, x=[32767,32767] -> h all -32768.
- Handshake: pulse start, re-pulse start at cycles 5 and 29 -> exactly one done pulse; busy high cycles 1–29; no second step begins.
- Reset mid-operation: deassert rst_n at cycle 12 of a step with nonzero prior h -> immediately busy=0, done=0, h_rd_data=0 for all indices; a new start after release completes normally.
- clear_h priority: h=[256,512,0,128], assert clear_h and start together in IDLE -> h all 0, busy stays 0. clear_h asserted while busy is ignored.

Source files
------------

// File: rtl/rnn_pkg.sv
// -----------------------------------------------------------------------------
// rnn_pkg
// Shared definitions for the recurrent-step sequencer: default vector and
// matrix dimensions, fixed-point formats and the controller state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package rnn_pkg;

   localparam int IN_DIM  = 2;   // input vector length (rows of W)
   localparam int HID_DIM = 4;   // hidden units
   localparam int DW      = 16;  // signed data width
   localparam int FRAC    = 8;   // fractional bits (Q8.8)
   localparam int ACC_W   = 40;  // accumulator width

   typedef logic signed [DW-1:0]    fixed_t;
   typedef logic signed [ACC_W-1:0] acc_t;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ACC_X  = 3'd1,
      ST_ACC_H  = 3'd2,
      ST_WRITE  = 3'd3,
      ST_COMMIT = 3'd4,
      ST_DONE   = 3'd5
   } ctrl_state_t;

endpackage : rnn_pkg

// File: rtl/rnn_mac.sv
// -----------------------------------------------------------------------------
// rnn_mac
// Single signed multiply-accumulate unit shared by every product of a step,
// plus the combinational output conditioning (rescale, saturate, activation)
// applied to the current accumulator contents.
//
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   clear       - zero the accumulator on the next edge (wins over en)
//   en          - add a*b into the accumulator on the next edge
//   a, b        - signed DW-bit operands
//   acc         - registered accumulator
//   act_out     - (acc >>> FRAC), saturated to DW bits, optional ReLU
// -----------------------------------------------------------------------------
module rnn_mac #(
   parameter int DW       = 16,
   parameter int FRAC     = 8,
   parameter int ACC_W    = 40,
   parameter int ACT_RELU = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    clear,
   input  logic                    en,
   input  logic signed [DW-1:0]    a,
   input  logic signed [DW-1:0]    b,
   output logic signed [ACC_W-1:0] acc,
   output logic signed [DW-1:0]    act_out
);

   localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'sd1 <<< (DW-1)) - 64'sd1);
   localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

   // Arithmetic shift floors toward -inf; the clamp then keeps the result
   // inside the DW-bit signed range.
   function automatic logic signed [DW-1:0] shift_sat(input logic signed [ACC_W-1:0] v);
      logic signed [ACC_W-1:0] r;
      r = v >>> FRAC;
      if (r > SAT_MAX) begin
         return SAT_MAX[DW-1:0];
      end else if (r < SAT_MIN) begin
         return SAT_MIN[DW-1:0];
      end
      return r[DW-1:0];
   endfunction

   function automatic logic signed [DW-1:0] activate(input logic signed [DW-1:0] v);
      if ((ACT_RELU != 0) && v[DW-1]) begin
         return '0;
      end
      return v;
   endfunction

   logic signed [2*DW-1:0]  prod;
   logic signed [ACC_W-1:0] prod_ext;
   logic signed [ACC_W-1:0] acc_d;
   logic signed [ACC_W-1:0] acc_q;

   always_comb begin
      prod     = a * b;
      prod_ext = {{(ACC_W-2*DW){prod[2*DW-1]}}, prod};
      acc_d    = acc_q;
      if (clear) begin
         acc_d = '0;
      end else if (en) begin
         acc_d = acc_q + prod_ext;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   assign acc     = acc_q;
   assign act_out = activate(shift_sat(acc_q));

endmodule : rnn_mac

// File: rtl/rnn_step_ctrl.sv
// -----------------------------------------------------------------------------
// rnn_step_ctrl
// Sequences one recurrent time step h_t = act(W*x + U*h_{t-1}) through a single
// shared MAC. For each hidden unit j it accumulates the IN_DIM input products,
// then the HID_DIM recurrent products against the committed h, then writes the
// conditioned result into h_next[j]. After the last unit, h_next is copied into
// h in one cycle so the host never observes a partially updated state.
//
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   start               - request one step (sampled in IDLE only)
//   clear_h             - zero hidden state (IDLE only, beats start)
//   busy                - step in progress
//   done                - one-cycle pulse when the step has committed
//   x_idx / x_data      - input vector read port (registered address)
//   w_row, w_col/w_data - W matrix read port (registered address)
//   u_row, u_col/u_data - U matrix read port (registered address)
//   h_rd_idx/h_rd_data  - host readback of the committed hidden state
// -----------------------------------------------------------------------------
module rnn_step_ctrl
   import rnn_pkg::*;
#(
   parameter int IN_DIM   = rnn_pkg::IN_DIM,
   parameter int HID_DIM  = rnn_pkg::HID_DIM,
   parameter int DW       = rnn_pkg::DW,
   parameter int FRAC     = rnn_pkg::FRAC,
   parameter int ACC_W    = rnn_pkg::ACC_W,
   parameter int ACT_RELU = 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic                       clear_h,
   output logic                       busy,
   output logic                       done,
   output logic [$clog2(IN_DIM)-1:0]  x_idx,
   input  logic signed [DW-1:0]       x_data,
   output logic [7:0]                 w_row,
   output logic [7:0]                 w_col,
   input  logic signed [DW-1:0]       w_data,
   output logic [7:0]                 u_row,
   output logic [7:0]                 u_col,
   input  logic signed [DW-1:0]       u_data,
   input  logic [$clog2(HID_DIM)-1:0] h_rd_idx,
   output logic signed [DW-1:0]       h_rd_data
);

   localparam int XW = $clog2(IN_DIM);
   localparam int HW = $clog2(HID_DIM);
   localparam logic [XW-1:0] I_LAST = XW'(IN_DIM - 1);
   localparam logic [HW-1:0] K_LAST = HW'(HID_DIM - 1);

   ctrl_state_t state_q, state_d;

   // i walks the input vector, k walks h, j selects the hidden unit being
   // computed. They double as the registered read addresses.
   logic [XW-1:0] i_q, i_d;
   logic [HW-1:0] j_q, j_d;
   logic [HW-1:0] k_q, k_d;

   logic signed [DW-1:0] h_q  [HID_DIM];
   logic signed [DW-1:0] h_d  [HID_DIM];
   logic signed [DW-1:0] hn_q [HID_DIM];
   logic signed [DW-1:0] hn_d [HID_DIM];

   logic                    mac_clear;
   logic                    mac_en;
   logic signed [DW-1:0]    mac_a;
   logic signed [DW-1:0]    mac_b;
   logic signed [ACC_W-1:0] mac_acc;
   logic signed [DW-1:0]    mac_act;

   rnn_mac #(
      .DW       (DW),
      .FRAC     (FRAC),
      .ACC_W    (ACC_W),
      .ACT_RELU (ACT_RELU)
   ) u_mac (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (mac_clear),
      .en      (mac_en),
      .a       (mac_a),
      .b       (mac_b),
      .acc     (mac_acc),
      .act_out (mac_act)
   );

   always_comb begin
      state_d   = state_q;
      i_d       = i_q;
      j_d       = j_q;
      k_d       = k_q;
      h_d       = h_q;
      hn_d      = hn_q;
      mac_clear = 1'b0;
      mac_en    = 1'b0;
      mac_a     = '0;
      mac_b     = '0;

      unique case (state_q)
         ST_IDLE: begin
            if (clear_h) begin
               for (int n = 0; n < HID_DIM; n++) begin
                  h_d[n] = '0;
               end
            end else if (start) begin
               state_d   = ST_ACC_X;
               i_d       = '0;
               j_d       = '0;
               k_d       = '0;
               mac_clear = 1'b1;
            end
         end

         ST_ACC_X: begin
            mac_en = 1'b1;
            mac_a  = x_data;
            mac_b  = w_data;
            if (i_q == I_LAST) begin
               i_d     = '0;
               k_d     = '0;
               state_d = ST_ACC_H;
            end else begin
               i_d = i_q + 1'b1;
            end
         end

         ST_ACC_H: begin
            // Recurrent term always uses the committed h, never h_next.
            mac_en = 1'b1;
            mac_a  = h_q[k_q];
            mac_b  = u_data;
            if (k_q == K_LAST) begin
               k_d     = '0;
               state_d = ST_WRITE;
            end else begin
               k_d = k_q + 1'b1;
            end
         end

         ST_WRITE: begin
            hn_d[j_q] = mac_act;
            mac_clear = 1'b1;
            if (j_q == K_LAST) begin
               j_d     = '0;
               state_d = ST_COMMIT;
            end else begin
               j_d     = j_q + 1'b1;
               state_d = ST_ACC_X;
            end
         end

         ST_COMMIT: begin
            h_d     = hn_q;
            state_d = ST_DONE;
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         i_q     <= '0;
         j_q     <= '0;
         k_q     <= '0;
         for (int n = 0; n < HID_DIM; n++) begin
            h_q[n]  <= '0;
            hn_q[n] <= '0;
         end
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         j_q     <= j_d;
         k_q     <= k_d;
         h_q     <= h_d;
         hn_q    <= hn_d;
      end
   end

   // Every unit starts from an empty accumulator: it was cleared either on
   // start or by the preceding WRITE.
   always_ff @(posedge clk) begin
      if (rst_n && (state_q == ST_ACC_X) && (i_q == '0)) begin
         assert (mac_acc == '0);
      end
   end

   assign busy      = (state_q == ST_ACC_X) || (state_q == ST_ACC_H) ||
                      (state_q == ST_WRITE) || (state_q == ST_COMMIT);
   assign done      = (state_q == ST_DONE);

   assign x_idx     = i_q;
   assign w_row     = 8'(i_q);
   assign w_col     = 8'(j_q);
   assign u_row     = 8'(k_q);
   assign u_col     = 8'(j_q);

   assign h_rd_data = h_q[h_rd_idx];

endmodule : rnn_step_ctrl

// File: tb/tb_rnn_step_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rnn_step_ctrl
// Two instances share one set of x/W/U arrays: dut_a uses ReLU, dut_b uses the
// identity activation. Table vectors cover the fixed scenarios, hand-written
// sequences cover handshake, clear and reset corners, and random steps are
// compared with a plain-arithmetic model of h_t = act(W*x + U*h_{t-1}).
// -----------------------------------------------------------------------------
module tb_rnn_step_ctrl;

   localparam int NI = 2;
   localparam int NH = 4;

   logic clk;
   logic rst_n;

   logic              start_a, clear_a, busy_a, done_a;
   logic [0:0]        x_idx_a;
   logic [7:0]        w_row_a, w_col_a, u_row_a, u_col_a;
   logic signed [15:0] x_data_a, w_data_a, u_data_a, h_rd_data_a;

   logic              start_b, clear_b, busy_b, done_b;
   logic [0:0]        x_idx_b;
   logic [7:0]        w_row_b, w_col_b, u_row_b, u_col_b;
   logic signed [15:0] x_data_b, w_data_b, u_data_b, h_rd_data_b;

   logic [1:0]        h_rd_idx;

   logic signed [15:0] x_mem [NI];
   logic signed [15:0] w_mem [NI][NH];
   logic signed [15:0] u_mem [NH][NH];

   longint mh [2][NH];   // model hidden state per instance

   int checks = 0;
   int errors = 0;

   typedef struct {
      int              sel;
      logic [1:0][15:0]  x;
      logic [7:0][15:0]  w;    // w[i*4+j] = W[i][j]
      logic [15:0][15:0] u;    // u[k*4+j] = U[k][j]
      logic [3:0][15:0]  exp;
   } vec_t;

   vec_t tv [5];

   rnn_step_ctrl #(.ACT_RELU(1)) dut_a (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start_a),
      .clear_h   (clear_a),
      .busy      (busy_a),
      .done      (done_a),
      .x_idx     (x_idx_a),
      .x_data    (x_data_a),
      .w_row     (w_row_a),
      .w_col     (w_col_a),
      .w_data    (w_data_a),
      .u_row     (u_row_a),
      .u_col     (u_col_a),
      .u_data    (u_data_a),
      .h_rd_idx  (h_rd_idx),
      .h_rd_data (h_rd_data_a)
   );

   rnn_step_ctrl #(.ACT_RELU(0)) dut_b (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start_b),
      .clear_h   (clear_b),
      .busy      (busy_b),
      .done      (done_b),
      .x_idx     (x_idx_b),
      .x_data    (x_data_b),
      .w_row     (w_row_b),
      .w_col     (w_col_b),
      .w_data    (w_data_b),
      .u_row     (u_row_b),
      .u_col     (u_col_b),
      .u_data    (u_data_b),
      .h_rd_idx  (h_rd_idx),
      .h_rd_data (h_rd_data_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Combinational storage reads; out-of-range addresses return a marker.
   always_comb begin
      x_data_a = x_mem[int'(x_idx_a)];
      x_data_b = x_mem[int'(x_idx_b)];
      w_data_a = 16'sh7ead;
      w_data_b = 16'sh7ead;
      u_data_a = 16'sh7ead;
      u_data_b = 16'sh7ead;
      if (int'(w_row_a) < NI && int'(w_col_a) < NH) w_data_a = w_mem[int'(w_row_a)][int'(w_col_a)];
      if (int'(w_row_b) < NI && int'(w_col_b) < NH) w_data_b = w_mem[int'(w_row_b)][int'(w_col_b)];
      if (int'(u_row_a) < NH && int'(u_col_a) < NH) u_data_a = u_mem[int'(u_row_a)][int'(u_col_a)];
      if (int'(u_row_b) < NH && int'(u_col_b) < NH) u_data_b = u_mem[int'(u_row_b)][int'(u_col_b)];
   end

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic logic done_of(input int s);
      return (s == 0) ? done_a : done_b;
   endfunction

   function automatic longint h_of(input int s);
      return (s == 0) ? longint'(h_rd_data_a) : longint'(h_rd_data_b);
   endfunction

   task automatic set_start(input int s, input logic v);
      if (s == 0) start_a = v;
      else        start_b = v;
   endtask

   // Reference: every unit uses the previous h; results commit together.
   function automatic void model_step(input int s);
      longint nh [NH];
      longint sum;
      longint r;
      for (int j = 0; j < NH; j++) begin
         sum = 0;
         for (int i = 0; i < NI; i++) sum += longint'(x_mem[i]) * longint'(w_mem[i][j]);
         for (int k = 0; k < NH; k++) sum += mh[s][k] * longint'(u_mem[k][j]);
         r = sum >>> 8;
         if (r > 32767)  r = 32767;
         if (r < -32768) r = -32768;
         if (s == 0 && r < 0) r = 0;
         nh[j] = r;
      end
      for (int j = 0; j < NH; j++) mh[s][j] = nh[j];
   endfunction

   task automatic check_h(input int s, input string tag);
      for (int n = 0; n < NH; n++) begin
         h_rd_idx = 2'(n);
         #1;
         check($sformatf("%s h%0d[%0d]", tag, s, n), h_of(s), mh[s][n]);
      end
   endtask

   // Start at edge 0 and expect done in cycle 30.
   task automatic run_step(input int s, input string tag);
      int cyc;
      @(negedge clk);
      set_start(s, 1'b1);
      @(negedge clk);
      set_start(s, 1'b0);
      cyc = 1;
      while (cyc < 100 && !done_of(s)) begin
         @(negedge clk);
         cyc++;
      end
      check({tag, " latency"}, done_of(s) ? longint'(cyc) : -1, 30);
   endtask

   task automatic load_vec(input int n);
      for (int i = 0; i < NI; i++) x_mem[i] = $signed(tv[n].x[i]);
      for (int i = 0; i < NI; i++)
         for (int j = 0; j < NH; j++) w_mem[i][j] = $signed(tv[n].w[i*NH+j]);
      for (int k = 0; k < NH; k++)
         for (int j = 0; j < NH; j++) u_mem[k][j] = $signed(tv[n].u[k*NH+j]);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int busy_err;
      int done_cnt;
      int done_at;

      rst_n    = 1'b0;
      start_a  = 1'b0; clear_a = 1'b0;
      start_b  = 1'b0; clear_b = 1'b0;
      h_rd_idx = '0;
      for (int s = 0; s < 2; s++)
         for (int n = 0; n < NH; n++) mh[s][n] = 0;

      // ---- vector table ----
      for (int n = 0; n < 5; n++) begin
         tv[n].sel = 0; tv[n].x = '0; tv[n].w = '0; tv[n].u = '0; tv[n].exp = '0;
      end
      tv[0].x[0] = 16'd256;
      tv[0].w[0] = 16'd256; tv[0].w[1] = 16'd512; tv[0].w[2] = 16'hff00; tv[0].w[3] = 16'd128;
      tv[0].exp[0] = 16'd256; tv[0].exp[1] = 16'd512; tv[0].exp[2] = 16'd0; tv[0].exp[3] = 16'd128;
      for (int k = 0; k < NH; k++) tv[1].u[k*NH+k] = 16'd256;
      tv[1].exp = tv[0].exp;
      tv[2].u = tv[1].u;
      tv[2].u[1] = 16'd256;
      tv[2].exp[0] = 16'd256; tv[2].exp[1] = 16'd768; tv[2].exp[2] = 16'd0; tv[2].exp[3] = 16'd128;
      tv[3].sel = 1;
      tv[3].x[0] = 16'h7fff; tv[3].x[1] = 16'h7fff;
      for (int m = 0; m < 8; m++) tv[3].w[m] = 16'h7fff;
      for (int m = 0; m < 4; m++) tv[3].exp[m] = 16'h7fff;
      tv[4].sel = 1;
      tv[4].x = tv[3].x;
      for (int m = 0; m < 8; m++) tv[4].w[m] = 16'h8000;
      for (int m = 0; m < 4; m++) tv[4].exp[m] = 16'h8000;
      load_vec(0);

      // ---- reset state ----
      #2;
      check("reset busy_a", longint'(busy_a), 0);
      check("reset done_a", longint'(done_a), 0);
      check("reset busy_b", longint'(busy_b), 0);
      check("reset addr_a", longint'({x_idx_a, w_row_a, w_col_a, u_row_a, u_col_a}), 0);
      check_h(0, "reset");
      check_h(1, "reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // ---- table-driven steps ----
      for (int n = 0; n < 5; n++) begin
         load_vec(n);
         run_step(tv[n].sel, $sformatf("vec%0d", n));
         for (int m = 0; m < NH; m++) begin
            h_rd_idx = 2'(m);
            #1;
            check($sformatf("vec%0d h[%0d]", n, m), h_of(tv[n].sel), longint'($signed(tv[n].exp[m])));
            mh[tv[n].sel][m] = longint'($signed(tv[n].exp[m]));
         end
      end

      // ---- clear_h beats start in IDLE ----
      @(negedge clk);
      clear_a = 1'b1; start_a = 1'b1;
      @(negedge clk);
      clear_a = 1'b0; start_a = 1'b0;
      busy_err = 0;
      for (int c = 0; c < 3; c++) begin
         if (busy_a !== 1'b0) busy_err++;
         @(negedge clk);
      end
      check("clear_prio busy", longint'(busy_err), 0);
      for (int n = 0; n < NH; n++) mh[0][n] = 0;
      check_h(0, "clear_prio");

      // ---- handshake: extra starts and a busy clear_h are ignored ----
      load_vec(0);
      model_step(0);
      @(negedge clk);
      start_a = 1'b1;
      busy_err = 0; done_cnt = 0; done_at = -1;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (busy_a !== (c <= 29)) busy_err++;
         if (done_a === 1'b1) begin
            done_cnt++;
            done_at = c;
         end
         start_a = (c == 5 || c == 29 || c == 30);
         clear_a = (c == 10);
      end
      start_a = 1'b0; clear_a = 1'b0;
      check("hs busy_window", longint'(busy_err), 0);
      check("hs done_count", longint'(done_cnt), 1);
      check("hs done_cycle", longint'(done_at), 30);
      check_h(0, "hs");

      // ---- asynchronous reset mid-step with nonzero h ----
      @(negedge clk);
      start_a = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         start_a = 1'b0;
      end
      rst_n = 1'b0;
      #1;
      check("rst_mid busy_a", longint'(busy_a), 0);
      check("rst_mid done_a", longint'(done_a), 0);
      check("rst_mid busy_b", longint'(busy_b), 0);
      check("rst_mid addr_a", longint'({x_idx_a, w_row_a, w_col_a, u_row_a, u_col_a}), 0);
      for (int s = 0; s < 2; s++)
         for (int n = 0; n < NH; n++) mh[s][n] = 0;
      check_h(0, "rst_mid");
      check_h(1, "rst_mid");
      @(negedge clk);
      rst_n = 1'b1;
      model_step(0);
      run_step(0, "post_rst");
      check_h(0, "post_rst");

      // ---- randomized steps against the model ----
      for (int it = 0; it < 8; it++) begin
         int s;
         s = it % 2;
         for (int i = 0; i < NI; i++) begin
            x_mem[i] = (it >= 6) ? 16'($urandom) : 16'(int'($urandom_range(1024)) - 512);
            for (int j = 0; j < NH; j++)
               w_mem[i][j] = (it >= 6) ? 16'($urandom) : 16'(int'($urandom_range(1024)) - 512);
         end
         for (int k = 0; k < NH; k++)
            for (int j = 0; j < NH; j++)
               u_mem[k][j] = (it >= 6) ? 16'($urandom) : 16'(int'($urandom_range(512)) - 256);
         model_step(s);
         run_step(s, $sformatf("rand%0d", it));
         check_h(s, $sformatf("rand%0d", it));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_rnn_step_ctrl
